// File: rtl/ecc_13_pkg.sv
// Shared widths, SECDED column table and capture-state type for the 13-bit ECC path.
package ecc_13_pkg;

  localparam int ECC13_DATA_W = 13;
  localparam int ECC13_PAR_W  = 6;

  // Data columns all have weight 3 and parity columns weight 1, so a double error yields
  // an even-weight syndrome that can never alias a single-bit error.
  localparam logic [ECC13_DATA_W-1:0][ECC13_PAR_W-1:0] ECC13_H_COLS = {
    6'b010110, 6'b010101, 6'b010011, 6'b111000, 6'b110100, 6'b110010, 6'b110001,
    6'b101100, 6'b101010, 6'b101001, 6'b100110, 6'b100101, 6'b100011
  };

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    CAPTURED = 1'b1
  } cap_state_e;

  function automatic logic [ECC13_PAR_W-1:0] ecc13_encode(input logic [ECC13_DATA_W-1:0] data);
    logic [ECC13_PAR_W-1:0] par;
    par = {ECC13_PAR_W{1'b0}};
    for (int i = 0; i < ECC13_DATA_W; i++) begin
      par = par ^ (ECC13_H_COLS[i] & {ECC13_PAR_W{data[i]}});
    end
    return par;
  endfunction

endpackage

// File: rtl/ecc_13_cal.sv
// Combinational SECDED checker/encoder for one 13-bit data + 6-bit parity word.
module ecc_13_cal
  import ecc_13_pkg::*;
(
  input  logic [ECC13_DATA_W-1:0] data,
  input  logic [ECC13_PAR_W-1:0]  parity,
  output logic [ECC13_DATA_W-1:0] corr_data,
  output logic [ECC13_PAR_W-1:0]  enc_parity,
  output logic                    sbit,
  output logic                    dbit,
  output logic                    data_fix
);

  logic [ECC13_PAR_W-1:0]  syndrome;
  logic [ECC13_DATA_W-1:0] flip;
  logic                    par_fix;

  always_comb begin
    enc_parity = ecc13_encode(data);
    syndrome   = enc_parity ^ parity;
    flip       = {ECC13_DATA_W{1'b0}};
    for (int i = 0; i < ECC13_DATA_W; i++) begin
      flip[i] = (syndrome == ECC13_H_COLS[i]);
    end
    data_fix  = |flip;
    par_fix   = $onehot(syndrome);
    sbit      = data_fix | par_fix;
    dbit      = (syndrome != {ECC13_PAR_W{1'b0}}) & ~sbit;
    corr_data = data ^ flip;
  end

endmodule

// File: rtl/ecc_13_rd_pipe.sv
// Registered read-side SECDED stage with error counters, first-dbit address capture and irq.
// Optional scrub write-back request when ECC_13_RD_PIPE_SCRUB_EN is defined.
module ecc_13_rd_pipe
  import ecc_13_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ECC13_DATA_W-1:0] in_data,
  input  logic [ECC13_PAR_W-1:0]  in_parity,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic                    bypass,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ECC13_DATA_W-1:0] out_data,
  output logic                    out_sbit,
  output logic                    out_dbit,
  input  logic                    clr,
  output logic [CNT_W-1:0]        sbit_cnt,
  output logic [CNT_W-1:0]        dbit_cnt,
  output logic [ADDR_W-1:0]       err_addr,
  output logic                    err_addr_vld,
  output logic                    irq
`ifdef ECC_13_RD_PIPE_SCRUB_EN
  ,
  output logic                    scrub_req,
  input  logic                    scrub_ack,
  output logic [ADDR_W-1:0]       scrub_addr,
  output logic [ECC13_DATA_W-1:0] scrub_data,
  output logic [ECC13_PAR_W-1:0]  scrub_parity
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [ECC13_DATA_W-1:0] cal_data;
  logic [ECC13_PAR_W-1:0]  cal_enc_unused;
  logic                    cal_sbit, cal_dbit, cal_fix;
  logic                    accept, hit_sbit, hit_dbit;

  logic                    out_valid_q, out_valid_d;
  logic [ECC13_DATA_W-1:0] out_data_q, out_data_d;
  logic                    out_sbit_q, out_sbit_d;
  logic                    out_dbit_q, out_dbit_d;
  logic [CNT_W-1:0]        sbit_cnt_q, sbit_cnt_d, sbit_base;
  logic [CNT_W-1:0]        dbit_cnt_q, dbit_cnt_d, dbit_base;
  cap_state_e              state_q, state_d, cap_base;
  logic [ADDR_W-1:0]       err_addr_q, err_addr_d;
  logic                    irq_q, irq_d;

  ecc_13_cal u_check (
    .data       (in_data),
    .parity     (in_parity),
    .corr_data  (cal_data),
    .enc_parity (cal_enc_unused),
    .sbit       (cal_sbit),
    .dbit       (cal_dbit),
    .data_fix   (cal_fix)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign hit_sbit = accept && !bypass && cal_sbit;
  assign hit_dbit = accept && !bypass && cal_dbit;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sbit_d  = out_sbit_q;
    out_dbit_d  = out_dbit_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = bypass ? in_data : cal_data;
      out_sbit_d  = hit_sbit;
      out_dbit_d  = hit_dbit;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // clr is applied before the event of the same cycle, so clr + error gives a count of 1.
  always_comb begin
    sbit_base = clr ? {CNT_W{1'b0}} : sbit_cnt_q;
    dbit_base = clr ? {CNT_W{1'b0}} : dbit_cnt_q;
    if (hit_sbit && (sbit_base != CNT_MAX)) begin
      sbit_cnt_d = sbit_base + CNT_ONE;
    end else begin
      sbit_cnt_d = sbit_base;
    end
    if (hit_dbit && (dbit_base != CNT_MAX)) begin
      dbit_cnt_d = dbit_base + CNT_ONE;
    end else begin
      dbit_cnt_d = dbit_base;
    end
  end

  always_comb begin
    cap_base   = clr ? IDLE : state_q;
    err_addr_d = clr ? {ADDR_W{1'b0}} : err_addr_q;
    state_d    = cap_base;
    case (cap_base)
      IDLE: begin
        if (hit_dbit) begin
          state_d    = CAPTURED;
          err_addr_d = in_addr;
        end else begin
          state_d = IDLE;
        end
      end
      CAPTURED: state_d = CAPTURED;
      default:  state_d = IDLE;
    endcase
    irq_d = (state_d == CAPTURED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {ECC13_DATA_W{1'b0}};
      out_sbit_q  <= 1'b0;
      out_dbit_q  <= 1'b0;
      sbit_cnt_q  <= {CNT_W{1'b0}};
      dbit_cnt_q  <= {CNT_W{1'b0}};
      state_q     <= IDLE;
      err_addr_q  <= {ADDR_W{1'b0}};
      irq_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sbit_q  <= out_sbit_d;
      out_dbit_q  <= out_dbit_d;
      sbit_cnt_q  <= sbit_cnt_d;
      dbit_cnt_q  <= dbit_cnt_d;
      state_q     <= state_d;
      err_addr_q  <= err_addr_d;
      irq_q       <= irq_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_sbit     = out_sbit_q;
  assign out_dbit     = out_dbit_q;
  assign sbit_cnt     = sbit_cnt_q;
  assign dbit_cnt     = dbit_cnt_q;
  assign err_addr     = err_addr_q;
  assign err_addr_vld = (state_q == CAPTURED);
  assign irq          = irq_q;

`ifdef ECC_13_RD_PIPE_SCRUB_EN
  logic [ECC13_PAR_W-1:0]  enc_parity;
  logic [ECC13_DATA_W-1:0] enc_data_unused;
  logic                    enc_sbit_unused, enc_dbit_unused, enc_fix_unused;
  logic                    scrub_req_q, scrub_req_d;
  logic [ADDR_W-1:0]       scrub_addr_q, scrub_addr_d;
  logic [ECC13_DATA_W-1:0] scrub_data_q, scrub_data_d;
  logic [ECC13_PAR_W-1:0]  scrub_parity_q, scrub_parity_d;

  ecc_13_cal u_scrub_enc (
    .data       (cal_data),
    .parity     ({ECC13_PAR_W{1'b0}}),
    .corr_data  (enc_data_unused),
    .enc_parity (enc_parity),
    .sbit       (enc_sbit_unused),
    .dbit       (enc_dbit_unused),
    .data_fix   (enc_fix_unused)
  );

  // Only data-bit corrections are rewritten; new requests while one is pending are dropped.
  always_comb begin
    scrub_req_d    = scrub_req_q;
    scrub_addr_d   = scrub_addr_q;
    scrub_data_d   = scrub_data_q;
    scrub_parity_d = scrub_parity_q;
    if (scrub_req_q) begin
      scrub_req_d = !scrub_ack;
    end else if (accept && !bypass && cal_fix) begin
      scrub_req_d    = 1'b1;
      scrub_addr_d   = in_addr;
      scrub_data_d   = cal_data;
      scrub_parity_d = enc_parity;
    end else begin
      scrub_req_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scrub_req_q    <= 1'b0;
      scrub_addr_q   <= {ADDR_W{1'b0}};
      scrub_data_q   <= {ECC13_DATA_W{1'b0}};
      scrub_parity_q <= {ECC13_PAR_W{1'b0}};
    end else begin
      scrub_req_q    <= scrub_req_d;
      scrub_addr_q   <= scrub_addr_d;
      scrub_data_q   <= scrub_data_d;
      scrub_parity_q <= scrub_parity_d;
    end
  end

  assign scrub_req    = scrub_req_q;
  assign scrub_addr   = scrub_addr_q;
  assign scrub_data   = scrub_data_q;
  assign scrub_parity = scrub_parity_q;
`endif

endmodule

// File: tb/tb_ecc_13_rd_pipe.sv
// Directed self-checking bench for ecc_13_rd_pipe; scrub checks compile in with ECC_13_RD_PIPE_SCRUB_EN.
`timescale 1ns/1ps
module tb_ecc_13_rd_pipe;

  localparam int ADDR_W = 6;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [12:0]       in_data = 13'h0;
  logic [5:0]        in_parity = 6'h0;
  logic [ADDR_W-1:0] in_addr = 6'h0;
  logic              bypass = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [12:0]       out_data;
  logic              out_sbit, out_dbit;
  logic              clr = 1'b0;
  logic [CNT_W-1:0]  sbit_cnt, dbit_cnt;
  logic [ADDR_W-1:0] err_addr;
  logic              err_addr_vld, irq;
`ifdef ECC_13_RD_PIPE_SCRUB_EN
  logic              scrub_req;
  logic              scrub_ack = 1'b0;
  logic [ADDR_W-1:0] scrub_addr;
  logic [12:0]       scrub_data;
  logic [5:0]        scrub_parity;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ecc_13_rd_pipe #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_parity(in_parity), .in_addr(in_addr), .bypass(bypass), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sbit(out_sbit), .out_dbit(out_dbit),
    .clr(clr), .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .err_addr(err_addr),
    .err_addr_vld(err_addr_vld), .irq(irq)
`ifdef ECC_13_RD_PIPE_SCRUB_EN
    , .scrub_req(scrub_req), .scrub_ack(scrub_ack), .scrub_addr(scrub_addr),
    .scrub_data(scrub_data), .scrub_parity(scrub_parity)
`endif
  );

  // Present one word for one clock edge, then return to idle #1 after that edge.
  task automatic put(input logic [12:0] d, input logic [5:0] p, input logic [5:0] a, input logic b);
    in_valid = 1'b1; in_data = d; in_parity = p; in_addr = a; bypass = b;
    @(posedge clk); #1;
    in_valid = 1'b0; bypass = 1'b0;
  endtask

  task automatic pulse_clr;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_data !== 13'h0000) begin n_fail++; $display("FAIL rst_out_data got %h want 0", out_data); end
    n_checks++; if ({sbit_cnt, dbit_cnt} !== 16'h0000) begin n_fail++; $display("FAIL rst_cnts got %h/%h want 0/0", sbit_cnt, dbit_cnt); end
    n_checks++; if ({err_addr_vld, irq, err_addr} !== 8'h00) begin n_fail++; $display("FAIL rst_capture got vld=%b irq=%b addr=%h want 0", err_addr_vld, irq, err_addr); end
`ifdef ECC_13_RD_PIPE_SCRUB_EN
    n_checks++; if (scrub_req !== 1'b0) begin n_fail++; $display("FAIL rst_scrub_req got %b want 0", scrub_req); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clean_and_sbit;
    put(13'h0000, 6'b000000, 6'd1, 1'b0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clean_valid got %b want 1", out_valid); end
    n_checks++; if ({out_data, out_sbit, out_dbit} !== {13'h0000, 2'b00}) begin n_fail++; $display("FAIL clean0 got %h s=%b d=%b want 0000 s=0 d=0", out_data, out_sbit, out_dbit); end
    put(13'h0005, 6'b000101, 6'd2, 1'b0);
    n_checks++; if ({out_data, out_sbit, out_dbit} !== {13'h0005, 2'b00}) begin n_fail++; $display("FAIL clean5 got %h s=%b d=%b want 0005 s=0 d=0", out_data, out_sbit, out_dbit); end
    put(13'h0000, 6'b100011, 6'd3, 1'b0);
    n_checks++; if ({out_data, out_sbit, out_dbit} !== {13'h0001, 2'b10}) begin n_fail++; $display("FAIL sbit_d0 got %h s=%b d=%b want 0001 s=1 d=0", out_data, out_sbit, out_dbit); end
    n_checks++; if (sbit_cnt !== 8'd1) begin n_fail++; $display("FAIL sbit_cnt1 got %0d want 1", sbit_cnt); end
`ifdef ECC_13_RD_PIPE_SCRUB_EN
    n_checks++; if ({scrub_req, scrub_addr, scrub_data, scrub_parity} !== {1'b1, 6'd3, 13'h0001, 6'b100011}) begin
      n_fail++; $display("FAIL scrub_set got req=%b a=%0d d=%h p=%b want 1 3 0001 100011", scrub_req, scrub_addr, scrub_data, scrub_parity); end
`endif
    put(13'h0000, 6'b010110, 6'd4, 1'b0);
    n_checks++; if ({out_data, out_sbit} !== {13'h1000, 1'b1}) begin n_fail++; $display("FAIL sbit_d12 got %h s=%b want 1000 s=1", out_data, out_sbit); end
    n_checks++; if (sbit_cnt !== 8'd2) begin n_fail++; $display("FAIL sbit_cnt2 got %0d want 2", sbit_cnt); end
`ifdef ECC_13_RD_PIPE_SCRUB_EN
    n_checks++; if ({scrub_req, scrub_addr} !== {1'b1, 6'd3}) begin n_fail++; $display("FAIL scrub_drop got req=%b a=%0d want 1 3", scrub_req, scrub_addr); end
    scrub_ack = 1'b1;
    @(posedge clk); #1;
    scrub_ack = 1'b0;
    n_checks++; if (scrub_req !== 1'b0) begin n_fail++; $display("FAIL scrub_ack got req=%b want 0", scrub_req); end
`else
    @(posedge clk); #1;
`endif
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b want 0", out_valid); end
  endtask

  task automatic test_parity_only;
    pulse_clr();
    put(13'h0000, 6'b000001, 6'd6, 1'b0);
    n_checks++; if ({out_data, out_sbit, out_dbit} !== {13'h0000, 2'b10}) begin n_fail++; $display("FAIL par_only got %h s=%b d=%b want 0000 s=1 d=0", out_data, out_sbit, out_dbit); end
    n_checks++; if (sbit_cnt !== 8'd1) begin n_fail++; $display("FAIL par_only_cnt got %0d want 1", sbit_cnt); end
`ifdef ECC_13_RD_PIPE_SCRUB_EN
    n_checks++; if (scrub_req !== 1'b0) begin n_fail++; $display("FAIL par_only_scrub got %b want 0", scrub_req); end
`endif
  endtask

  task automatic test_dbit_capture;
    pulse_clr();
    n_checks++; if ({err_addr_vld, irq, sbit_cnt} !== {2'b00, 8'd0}) begin n_fail++; $display("FAIL clr_state got vld=%b irq=%b sc=%0d want 0 0 0", err_addr_vld, irq, sbit_cnt); end
    put(13'h0003, 6'b000000, 6'd5, 1'b0);
    n_checks++; if ({out_data, out_sbit, out_dbit} !== {13'h0003, 2'b01}) begin n_fail++; $display("FAIL dbit_out got %h s=%b d=%b want 0003 s=0 d=1", out_data, out_sbit, out_dbit); end
    n_checks++; if ({dbit_cnt, err_addr, err_addr_vld, irq} !== {8'd1, 6'd5, 2'b11}) begin
      n_fail++; $display("FAIL dbit_cap got dc=%0d a=%0d vld=%b irq=%b want 1 5 1 1", dbit_cnt, err_addr, err_addr_vld, irq); end
    put(13'h0003, 6'b000000, 6'd9, 1'b0);
    n_checks++; if ({dbit_cnt, err_addr, err_addr_vld} !== {8'd2, 6'd5, 1'b1}) begin
      n_fail++; $display("FAIL dbit_sticky got dc=%0d a=%0d vld=%b want 2 5 1", dbit_cnt, err_addr, err_addr_vld); end
    clr = 1'b1;
    put(13'h0003, 6'b000000, 6'd7, 1'b0);
    clr = 1'b0;
    n_checks++; if ({dbit_cnt, err_addr, err_addr_vld, irq} !== {8'd1, 6'd7, 2'b11}) begin
      n_fail++; $display("FAIL clr_dbit got dc=%0d a=%0d vld=%b irq=%b want 1 7 1 1", dbit_cnt, err_addr, err_addr_vld, irq); end
  endtask

  task automatic test_bypass;
    pulse_clr();
    put(13'h0003, 6'b000000, 6'd8, 1'b1);
    n_checks++; if ({out_data, out_sbit, out_dbit} !== {13'h0003, 2'b00}) begin n_fail++; $display("FAIL byp_dbit got %h s=%b d=%b want 0003 s=0 d=0", out_data, out_sbit, out_dbit); end
    n_checks++; if ({dbit_cnt, err_addr_vld} !== {8'd0, 1'b0}) begin n_fail++; $display("FAIL byp_nocap got dc=%0d vld=%b want 0 0", dbit_cnt, err_addr_vld); end
    put(13'h0000, 6'b100011, 6'd8, 1'b1);
    n_checks++; if ({out_data, out_sbit, sbit_cnt} !== {13'h0000, 1'b0, 8'd0}) begin n_fail++; $display("FAIL byp_sbit got %h s=%b sc=%0d want 0000 0 0", out_data, out_sbit, sbit_cnt); end
`ifdef ECC_13_RD_PIPE_SCRUB_EN
    n_checks++; if (scrub_req !== 1'b0) begin n_fail++; $display("FAIL byp_scrub got %b want 0", scrub_req); end
`endif
  endtask

  task automatic test_back_to_back;
    pulse_clr();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 13'h0000; in_parity = 6'b100011; in_addr = 6'd0;
    @(posedge clk); #1;
    in_parity = 6'b100101;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++; if ({in_ready, out_valid, out_data, sbit_cnt} !== {2'b01, 13'h0001, 8'd1}) begin
        n_fail++; $display("FAIL stall%0d got rdy=%b v=%b d=%h sc=%0d want 0 1 0001 1", i, in_ready, out_valid, out_data, sbit_cnt); end
    end
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_rdy got %b want 1", in_ready); end
    @(posedge clk); #1;
    n_checks++; if ({out_data, sbit_cnt} !== {13'h0002, 8'd2}) begin n_fail++; $display("FAIL stream_b got %h sc=%0d want 0002 2", out_data, sbit_cnt); end
    in_parity = 6'b100110;
    @(posedge clk); #1;
    n_checks++; if ({out_data, sbit_cnt} !== {13'h0004, 8'd3}) begin n_fail++; $display("FAIL stream_c got %h sc=%0d want 0004 3", out_data, sbit_cnt); end
    in_parity = 6'b101001;
    @(posedge clk); #1;
    n_checks++; if ({out_valid, out_data, sbit_cnt} !== {1'b1, 13'h0008, 8'd4}) begin n_fail++; $display("FAIL stream_d got v=%b %h sc=%0d want 1 0008 4", out_valid, out_data, sbit_cnt); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({out_valid, sbit_cnt} !== {1'b0, 8'd4}) begin n_fail++; $display("FAIL stream_end got v=%b sc=%0d want 0 4", out_valid, sbit_cnt); end
  endtask

  task automatic test_saturation_clear;
    pulse_clr();
    in_valid = 1'b1; in_data = 13'h0000; in_parity = 6'b100011; in_addr = 6'd1;
    repeat (300) @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++; if ({sbit_cnt, dbit_cnt} !== {8'd255, 8'd0}) begin n_fail++; $display("FAIL saturate got sc=%0d dc=%0d want 255 0", sbit_cnt, dbit_cnt); end
    clr = 1'b1;
    put(13'h0000, 6'b100011, 6'd1, 1'b0);
    clr = 1'b0;
    n_checks++; if (sbit_cnt !== 8'd1) begin n_fail++; $display("FAIL clr_sbit got sc=%0d want 1", sbit_cnt); end
  endtask

  task automatic test_rst_midstream;
    put(13'h0003, 6'b000000, 6'd5, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 13'h0000; in_parity = 6'b100011; in_addr = 6'd2;
    @(posedge clk); #1;
    n_checks++; if ({out_valid, in_ready, sbit_cnt, irq} !== {2'b10, 8'd2, 1'b1}) begin
      n_fail++; $display("FAIL pre_rst got v=%b rdy=%b sc=%0d irq=%b want 1 0 2 1", out_valid, in_ready, sbit_cnt, irq); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if ({out_valid, in_ready, out_sbit, out_dbit} !== 4'b0100) begin n_fail++; $display("FAIL rst_mid_hs got v=%b rdy=%b s=%b d=%b want 0 1 0 0", out_valid, in_ready, out_sbit, out_dbit); end
    n_checks++; if ({out_data, sbit_cnt, dbit_cnt} !== {13'h0000, 8'd0, 8'd0}) begin n_fail++; $display("FAIL rst_mid_data got %h sc=%0d dc=%0d want 0 0 0", out_data, sbit_cnt, dbit_cnt); end
    n_checks++; if ({err_addr, err_addr_vld, irq} !== {6'd0, 2'b00}) begin n_fail++; $display("FAIL rst_mid_cap got a=%0d vld=%b irq=%b want 0 0 0", err_addr, err_addr_vld, irq); end
`ifdef ECC_13_RD_PIPE_SCRUB_EN
    n_checks++; if ({scrub_req, scrub_addr, scrub_data, scrub_parity} !== {1'b0, 6'd0, 13'h0, 6'd0}) begin n_fail++; $display("FAIL rst_mid_scrub got req=%b a=%0d", scrub_req, scrub_addr); end
`endif
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_and_sbit();
    test_parity_only();
    test_dbit_capture();
    test_bypass();
    test_back_to_back();
    test_saturation_clear();
    test_rst_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
